// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences one req/ack transaction at a time
// onto a single-port synchronous memory (registered read data, 4 cycles per access).
module mem_arbiter #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   // port 0 (CPU)
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   // port 1 (DMA / UART loader)
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   // memory side
   output logic          MemRead,
   output logic          MemWrite,
   output logic [AW-1:0] ADDR,
   output logic [DW-1:0] Data_in,
   input  logic [DW-1:0] Data_out,
   // status
   output logic          busy,
   output logic          gnt_id,
   output logic [1:0]    dbg_state_o
);

   // Handshake: a port raises reqN with weN/addrN/wdataN stable; operands are
   // captured only on the grant edge in IDLE, and ackN pulses for exactly one
   // cycle when the access is complete. rdataN is valid from that pulse onward.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          ptr_q, ptr_d;      // 1 = port 1 favoured on a tie
   logic          op_q, op_d;        // 1 = write
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          grant_sel;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         ptr_q    <= 1'b0;
         op_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         ptr_q    <= ptr_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      grant_sel = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // A lone requester wins regardless of the pointer.
               grant_sel = (req0 && req1) ? ptr_q : req1;
               gnt_d     = grant_sel;
               op_d      = grant_sel ? we1    : we0;
               addr_d    = grant_sel ? addr1  : addr0;
               wdata_d   = grant_sel ? wdata1 : wdata0;
               ptr_d     = ~grant_sel;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            state_d = RESP;
         end
         RESP: begin
            if (!op_q) begin
               if (gnt_q) rdata1_d = Data_out;
               else       rdata0_d = Data_out;
            end
            state_d = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory strobes decode from state only, so req never reaches the pins combinationally.
   assign MemRead     = (state_q == ISSUE) && !op_q;
   assign MemWrite    = (state_q == ISSUE) &&  op_q;
   assign ADDR        = addr_q;
   assign Data_in     = wdata_q;

   assign ack0        = (state_q == ACK) && !gnt_q;
   assign ack1        = (state_q == ACK) &&  gnt_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;

   assign busy        = (state_q != IDLE);
   assign gnt_id      = gnt_q;
   assign dbg_state_o = state_q;

endmodule
